// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the fetch PC, issues word requests to
// instruction memory and buffers in-order responses in a PC-tagged prefetch
// FIFO. Redirects flush the FIFO and drop responses still in flight.
module fetch_prefetch_unit #(
    parameter int              XLEN     = 32,
    parameter int              ADDR_W   = 8,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              fetch_en,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [31:0]       imem_rsp_data,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [31:0]       instr,
    output logic [XLEN-1:0]   instr_pc,
    output logic [XLEN-1:0]   instr_pc_plus4,
    output logic              misalign_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(DEPTH);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]   out_q, out_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic            mis_q, mis_d;

    logic [31:0]     mem_data [DEPTH];
    logic [XLEN-1:0] mem_pc   [DEPTH];

    logic [CW:0] credit_used;
    logic        accept;
    logic        push;
    logic        pop;

    // Credit: FIFO slots already taken plus live (non-dropped) requests in flight.
    // drop_q never exceeds out_q, so the subtraction cannot underflow.
    assign credit_used = {1'b0, cnt_q} + {1'b0, out_q} - {1'b0, drop_q};

    assign imem_req_valid = reset & fetch_en & ~redirect_valid
                          & ({1'b0, out_q} < DEPTH_C) & (credit_used < DEPTH_C);
    assign imem_addr      = fetch_pc_q[ADDR_W+1:2];
    assign accept         = imem_req_valid & imem_req_ready;
    assign push           = imem_rsp_valid & (drop_q == '0) & ~redirect_valid;
    assign pop            = (cnt_q != '0) & instr_ready & ~redirect_valid;

    // Head outputs are forced to zero whenever the FIFO is empty.
    assign instr_valid    = (cnt_q != '0);
    assign instr          = instr_valid ? mem_data[rd_q] : '0;
    assign instr_pc       = instr_valid ? mem_pc[rd_q] : '0;
    assign instr_pc_plus4 = instr_valid ? mem_pc[rd_q] + XLEN'(4) : '0;
    assign misalign_err   = mis_q;

    // Next-state: issue/response/pop bookkeeping, with redirect overriding all.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        resp_pc_d  = resp_pc_q;
        out_d      = out_q + CW'(accept) - CW'(imem_rsp_valid);
        drop_d     = drop_q;
        cnt_d      = cnt_q + CW'(push) - CW'(pop);
        wr_d       = wr_q;
        rd_d       = rd_q;
        mis_d      = redirect_valid & (redirect_pc[1:0] != 2'b00);

        if (accept)
            fetch_pc_d = fetch_pc_q + XLEN'(4);
        if (imem_rsp_valid && drop_q != '0)
            drop_d = drop_q - CW'(1);
        if (push) begin
            resp_pc_d = resp_pc_q + XLEN'(4);
            wr_d      = wr_q + PW'(1);
        end
        if (pop)
            rd_d = rd_q + PW'(1);

        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[XLEN-1:2], 2'b00};
            resp_pc_d  = {redirect_pc[XLEN-1:2], 2'b00};
            // Everything still outstanding is stale; a response landing now is too.
            drop_d     = out_q - CW'(imem_rsp_valid);
            cnt_d      = '0;
            wr_d       = '0;
            rd_d       = '0;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            out_q      <= '0;
            drop_q     <= '0;
            cnt_q      <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
            mis_q      <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            resp_pc_q  <= resp_pc_d;
            out_q      <= out_d;
            drop_q     <= drop_d;
            cnt_q      <= cnt_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
            mis_q      <= mis_d;
        end
    end

    // FIFO storage; contents are only observable through cnt_q, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_data[wr_q] <= imem_rsp_data;
            mem_pc[wr_q]   <= resp_pc_q;
        end
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction-fetch front end for the RV32I core. It replaces the single-register PC-plus-adder fetch path. It owns the fetch PC and issues word requests to instruction memory over a valid/ready port, tolerating variable response latency. In-order responses are buffered in a DEPTH-entry prefetch FIFO tagged with their PC. Branch/jump redirects from the execute stage flush the FIFO and discard stale in-flight responses.

Parameters:
XLEN, 32, PC/instruction width
ADDR_W, 8, instruction-memory word-address width (imem_addr = pc[ADDR_W+1:2])
DEPTH, 4, prefetch FIFO entries, power of two, >=2; also max outstanding requests
RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
fetch_en  in  1  1 = new imem requests allowed
redirect_valid  in  1  branch/jal/jalr taken this cycle
redirect_pc  in  XLEN  target PC
imem_req_valid  out  1  request valid
imem_req_ready  in  1  memory accepts request
imem_addr  out  ADDR_W  word address of request
imem_rsp_valid  in  1  response data valid, in request order, at least 1 cycle after acceptance
imem_rsp_data  in  32  instruction word
instr_valid  out  1  FIFO head valid
instr_ready  in  1  decode consumes head
instr  out  32  head instruction
instr_pc  out  XLEN  PC of head instruction
instr_pc_plus4  out  XLEN  instr_pc + 4, for jal/jalr link
misalign_err  out  1  one-cycle pulse: redirect_pc[1:0] != 0

Behaviour:
- Reset (reset=0, async): fetch_pc=resp_pc=RESET_PC; FIFO empty; outstanding=0; drop_cnt=0; all outputs 0 except imem_addr=RESET_PC[ADDR_W+1:2].
- Counters: outstanding and drop_cnt are $clog2(DEPTH+1) bits. outstanding counts accepted requests not yet responded, including ones to be dropped.
- Issue: imem_req_valid = fetch_en & !redirect_valid & (outstanding < DEPTH) & (fifo_count + outstanding - drop_cnt < DEPTH).
  - imem_addr = fetch_pc[ADDR_W+1:2].
  - imem_req_valid is combinational; the request is held stable while valid & !ready unless a redirect arrives.
  - On accept (valid & ready): fetch_pc += 4 (mod 2^XLEN, wraps), outstanding++.
- Response: on imem_rsp_valid, outstanding--.
  - If drop_cnt>0: drop_cnt--, data discarded.
  - Else: push {data, resp_pc} into FIFO; resp_pc += 4.
  - Pushed data reaches instr_valid the next cycle.
- Pop: instr_valid = !empty. Head is removed on instr_valid & instr_ready. Push and pop in the same cycle are allowed and the count is unchanged. The credit rule guarantees no push when full.
- Redirect (highest priority):
  - fetch_pc and resp_pc <= {redirect_pc[XLEN-1:2],2'b00}.
  - FIFO cleared; any same-cycle pop or push is ignored.
  - drop_cnt <= outstanding - (imem_rsp_valid ? 1 : 0); a response arriving that cycle is discarded.
  - No request is issued that cycle.
  - misalign_err <= (redirect_pc[1:0] != 0) for one cycle.
- Back-to-back redirects: each recomputes drop_cnt from the current outstanding; the last target wins.
- Latency: with redirect at cycle t and memory answering 1 cycle after accept, the request is issued at t+1, the response returns at t+2, and instr_valid is asserted at t+3.
- With instr_ready=1 and a 1-cycle memory, steady-state throughput is one instruction per cycle.
- fetch_en=0 blocks new issues only; in-flight responses still land and the FIFO still drains.

Test Plan:
- Reset release, RESET_PC=0, 1-cycle memory, instr_ready=1 -> imem_addr 0,1,2,…; instr_pc 0x0,0x4,0x8 on consecutive cycles; first instr_valid 2 cycles after the first accept.
- instr_ready=0 for 10 cycles, DEPTH=4 -> exactly 4 requests accepted, FIFO full, imem_req_valid=0; release -> 4 pops in order, fetching resumes.
- Memory latency 3, redirect to 0x40 with 2 outstanding -> both stale responses dropped; the first instr after redirect has instr_pc=0x40 and instr_pc_plus4=0x44.
- Redirect in the same cycle as imem_rsp_valid and an instr_ready pop -> FIFO empty next cycle; drop_cnt = outstanding-1; no request that cycle.
- Redirect to 0x102 -> misalign_err pulses once; fetch resumes at 0x100.
- fetch_pc=0xFFFF_FFFC -> next request at address 0 (wrap); reset asserted mid-burst -> all state returns to reset values immediately, asynchronously.
